// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder sequencer: register offsets,
// CTRL/STATUS bit positions and the pass-sequencing state encoding.
package ksa_pkg;

    localparam logic [2:0] OffOpa    = 3'd0;
    localparam logic [2:0] OffOpb    = 3'd1;
    localparam logic [2:0] OffCtrl   = 3'd2;
    localparam logic [2:0] OffResult = 3'd3;
    localparam logic [2:0] OffStatus = 3'd4;

    localparam int unsigned CtrlStart = 0;
    localparam int unsigned CtrlWide  = 1;
    localparam int unsigned CtrlIrqEn = 2;

    localparam int unsigned StatBusy = 0;
    localparam int unsigned StatDone = 1;
    localparam int unsigned StatCout = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StFix  = 2'd3
    } seq_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  sel);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/ksa_seq_fsm.sv
// Pass sequencer: latches operands on start, drives the external 16-bit adder
// and assembles 16- or 32-bit results from its sum/carry over up to three passes.
module ksa_seq_fsm import ksa_pkg::*; (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        wide_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic [15:0] add_sum_i,
    input  logic        add_cout_i,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    output logic        busy_o,
    output logic        done_set_o,
    output logic [31:0] result_o,
    output logic        cout_o
);

    seq_state_e  state_q, state_d;
    logic [31:0] wa_q, wa_d, wb_q, wb_d, result_q, result_d;
    logic [15:0] s_hi_q, s_hi_d, a_q, a_d, b_q, b_d;
    logic        wide_q, wide_d, c_lo_q, c_lo_d, c_hi_q, c_hi_d, cout_q, cout_d;
    logic        done_set;

    always_comb begin
        state_d  = state_q;
        wa_d     = wa_q;
        wb_d     = wb_q;
        wide_d   = wide_q;
        result_d = result_q;
        s_hi_d   = s_hi_q;
        c_lo_d   = c_lo_q;
        c_hi_d   = c_hi_q;
        cout_d   = cout_q;
        done_set = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    wa_d    = opa_i;
                    wb_d    = opb_i;
                    wide_d  = wide_i;
                    state_d = StLo;
                end
            end
            StLo: begin
                result_d[15:0] = add_sum_i;
                c_lo_d         = add_cout_i;
                if (wide_q) begin
                    state_d = StHi;
                end else begin
                    result_d[31:16] = 16'h0;
                    cout_d          = add_cout_i;
                    done_set        = 1'b1;
                    state_d         = StIdle;
                end
            end
            StHi: begin
                s_hi_d  = add_sum_i;
                c_hi_d  = add_cout_i;
                state_d = StFix;
            end
            StFix: begin
                // Fold the low-half carry into the upper sum; at most one of the carries can be set.
                result_d[31:16] = add_sum_i;
                cout_d          = c_hi_q | add_cout_i;
                done_set        = 1'b1;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Adder drives are registered from the next state so they line up with it.
        a_d = 16'h0;
        b_d = 16'h0;
        case (state_d)
            StLo: begin
                a_d = wa_d[15:0];
                b_d = wb_d[15:0];
            end
            StHi: begin
                a_d = wa_d[31:16];
                b_d = wb_d[31:16];
            end
            StFix: begin
                a_d = s_hi_d;
                b_d = {15'h0, c_lo_d};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            wa_q     <= 32'h0;
            wb_q     <= 32'h0;
            wide_q   <= 1'b0;
            result_q <= 32'h0;
            s_hi_q   <= 16'h0;
            c_lo_q   <= 1'b0;
            c_hi_q   <= 1'b0;
            cout_q   <= 1'b0;
            a_q      <= 16'h0;
            b_q      <= 16'h0;
        end else begin
            state_q  <= state_d;
            wa_q     <= wa_d;
            wb_q     <= wb_d;
            wide_q   <= wide_d;
            result_q <= result_d;
            s_hi_q   <= s_hi_d;
            c_lo_q   <= c_lo_d;
            c_hi_q   <= c_hi_d;
            cout_q   <= cout_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign add_a_o    = a_q;
    assign add_b_o    = b_q;
    assign busy_o     = (state_q != StIdle);
    assign done_set_o = done_set;
    assign result_o   = result_q;
    assign cout_o     = cout_q;

endmodule

// File: rtl/ksa16_wb_sequencer.sv
// Wishbone register front-end for the 16-bit Kogge-Stone adder: operand/control
// registers, sticky DONE with interrupt, and the pass sequencer instance.
module ksa16_wb_sequencer import ksa_pkg::*; #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] add_a_o,
    output logic [15:0] add_b_o,
    input  logic [15:0] add_sum_i,
    input  logic        add_cout_i,
    output logic        irq_o
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d, opa_q, opa_d, opb_q, opb_d;
    logic        wide_q, wide_d, irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;
    logic        req, acc, wr, start;
    logic [2:0]  off;
    logic        busy, done_set, fsm_cout;
    logic [31:0] result;
    logic        unused_adr;

    // Gating on ack_q gives one ack per request while the master still holds stb.
    assign req        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc        = req & ~ack_q;
    assign wr         = acc & wbs_we_i;
    assign off        = wbs_adr_i[4:2];
    assign start      = wr && (off == OffCtrl) && wbs_dat_i[CtrlStart] && !busy;
    assign unused_adr = ^{wbs_adr_i[7:5], wbs_adr_i[1:0]};

    always_comb begin
        ack_d    = acc;
        opa_d    = opa_q;
        opb_d    = opb_q;
        wide_d   = wide_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        dat_d    = 32'h0;

        if (wr) begin
            case (off)
                OffOpa:  opa_d = byte_merge(opa_q, wbs_dat_i, wbs_sel_i);
                OffOpb:  opb_d = byte_merge(opb_q, wbs_dat_i, wbs_sel_i);
                OffCtrl: begin
                    wide_d   = wbs_dat_i[CtrlWide];
                    irq_en_d = wbs_dat_i[CtrlIrqEn];
                end
                OffStatus: if (wbs_dat_i[StatDone]) done_d = 1'b0;
                default: ;
            endcase
        end
        if (start)    done_d = 1'b0;
        if (done_set) done_d = 1'b1;
        irq_d = done_d & irq_en_d;

        if (acc && !wbs_we_i) begin
            case (off)
                OffOpa:    dat_d = opa_q;
                OffOpb:    dat_d = opb_q;
                OffCtrl:   dat_d = {29'h0, irq_en_q, wide_q, 1'b0};
                OffResult: dat_d = result;
                OffStatus: dat_d = {29'h0, fsm_cout, done_q, busy};
                default:   dat_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            opa_q    <= 32'h0;
            opb_q    <= 32'h0;
            wide_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            wide_q   <= wide_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            irq_q    <= irq_d;
        end
    end

    ksa_seq_fsm u_fsm (
        .clk_i      (wb_clk_i),
        .rst_i      (wb_rst_i),
        .start_i    (start),
        .wide_i     (wbs_dat_i[CtrlWide]),
        .opa_i      (opa_q),
        .opb_i      (opb_q),
        .add_sum_i  (add_sum_i),
        .add_cout_i (add_cout_i),
        .add_a_o    (add_a_o),
        .add_b_o    (add_b_o),
        .busy_o     (busy),
        .done_set_o (done_set),
        .result_o   (result),
        .cout_o     (fsm_cout)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_ksa16_wb_sequencer.sv
// Randomised scoreboard bench for ksa16_wb_sequencer with a behavioural adder
// and a register-level reference model of the sequencer.
module tb_ksa16_wb_sequencer;

    localparam logic [31:0] Base = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic [15:0] add_a, add_b, add_sum;
    logic        add_cout, irq;
    logic [16:0] add_full;

    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational Kogge-Stone adder.
    assign add_full = {1'b0, add_a} + {1'b0, add_b};
    assign add_sum  = add_full[15:0];
    assign add_cout = add_full[16];

    ksa16_wb_sequencer #(.BASE_ADDR(Base)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_stb_i  (stb),
        .wbs_cyc_i  (cyc),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .add_a_o    (add_a),
        .add_b_o    (add_b),
        .add_sum_i  (add_sum),
        .add_cout_i (add_cout),
        .irq_o      (irq)
    );

    typedef struct {
        logic [31:0] data;
        bit          chk;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state.
    logic [31:0] m_opa, m_opb, m_result, p_result;
    logic        m_wide, m_irqen, m_done, m_cout, p_cout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (ack) begin
            if (sb.size() == 0) begin
                check("stray_ack", {31'h0, ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                if (e.chk) check(e.name, rdat, e.data);
            end
        end
    end

    function automatic logic [31:0] exp_reg(input int off);
        case (off)
            0:       return m_opa;
            1:       return m_opb;
            2:       return {29'h0, m_irqen, m_wide, 1'b0};
            3:       return m_result;
            4:       return {29'h0, m_cout, m_done, 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_opa = 0; m_opb = 0; m_result = 0; m_wide = 0; m_irqen = 0; m_done = 0; m_cout = 0;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output bit got);
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d; sel = s;
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ack) got = 1'b1;
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input int off, input logic [31:0] d, input logic [3:0] s);
        bit got;
        sb_t e;
        e.data = 0; e.chk = 0; e.name = "wr";
        sb.push_back(e);
        case (off)
            0: for (int i = 0; i < 4; i++) if (s[i]) m_opa[8*i +: 8] = d[8*i +: 8];
            1: for (int i = 0; i < 4; i++) if (s[i]) m_opb[8*i +: 8] = d[8*i +: 8];
            2: begin m_wide = d[1]; m_irqen = d[2]; end
            4: if (d[1]) m_done = 1'b0;
            default: ;
        endcase
        xfer(Base + 32'(off * 4), d, s, 1'b1, got);
        if (!got) check("wr_ack_timeout", {31'h0, got}, 32'h1);
    endtask

    task automatic rd(input int off, input string name);
        bit got;
        sb_t e;
        e.data = exp_reg(off); e.chk = 1; e.name = name;
        sb.push_back(e);
        xfer(Base + 32'(off * 4), 32'h0, 4'hF, 1'b0, got);
        if (!got) check("rd_ack_timeout", {31'h0, got}, 32'h1);
    endtask

    // Accepted START: latch operands into the pending result and clear DONE.
    task automatic start(input bit wide, input bit irqen);
        logic [32:0] s33;
        logic [16:0] s17;
        s33 = {1'b0, m_opa} + {1'b0, m_opb};
        s17 = {1'b0, m_opa[15:0]} + {1'b0, m_opb[15:0]};
        p_result = wide ? s33[31:0] : {16'h0, s17[15:0]};
        p_cout   = wide ? s33[32] : s17[16];
        wr(2, {29'h0, irqen, wide, 1'b1}, 4'hF);
        m_done = 1'b0;
    endtask

    task automatic finish_op();
        m_done = 1'b1; m_result = p_result; m_cout = p_cout;
    endtask

    task automatic run_add(input logic [31:0] a, input logic [31:0] b,
                           input bit wide, input bit irqen);
        int lat;
        lat = wide ? 3 : 1;
        wr(0, a, 4'hF);
        wr(1, b, 4'hF);
        start(wide, irqen);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("irq_latency", {31'h0, irq}, {31'h0, (irqen && k >= lat)});
        end
        finish_op();
        rd(3, "result");
        rd(4, "status");
        rd(2, "ctrl");
        check("irq_level", {31'h0, irq}, {31'h0, m_done & m_irqen});
    endtask

    initial begin
        bit got;
        rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; adr = 0; wdat = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_add_a", {16'h0, add_a}, 32'h0);
        check("rst_add_b", {16'h0, add_b}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        rst = 1'b0;
        for (int r = 0; r < 5; r++) rd(r, "rst_reg");

        // Directed carry cases.
        run_add(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_add(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b1);
        run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0);

        // Operand rewrite during BUSY does not disturb the in-flight add.
        wr(0, 32'h0000_00F0, 4'hF);
        wr(1, 32'h0001_0010, 4'hF);
        start(1'b1, 1'b0);
        wr(0, 32'h1234_5678, 4'hF);
        repeat (3) @(posedge clk);
        finish_op();
        rd(3, "busy_rewrite_result");
        rd(0, "busy_rewrite_opa");

        // Second START while busy is ignored but its WIDE/IRQ_EN bits land.
        start(1'b1, 1'b0);
        wr(2, 32'h0000_0005, 4'hF);
        repeat (4) @(posedge clk);
        finish_op();
        rd(3, "ignored_start_result");
        rd(4, "ignored_start_status");
        rd(2, "ignored_start_ctrl");

        // IRQ and write-1-to-clear DONE.
        run_add(32'h0000_8000, 32'h0000_8000, 1'b0, 1'b1);
        wr(4, 32'h0000_0002, 4'hF);
        check("irq_after_clear", {31'h0, irq}, 32'h0);
        rd(4, "status_after_clear");

        // Byte selects, unmapped offset, out-of-range address.
        wr(0, 32'h0, 4'hF);
        wr(0, 32'hAABB_CCDD, 4'b0100);
        rd(0, "byte_sel_opa");
        rd(5, "unmapped_rd");
        xfer(32'h3000_0100, 32'h0, 4'hF, 1'b0, got);
        check("oob_no_ack", {31'h0, got}, 32'h0);

        // Randomised adds.
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = $urandom();
            if (n % 4 == 0) a[15:0] = 16'hFFFF;
            run_add(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (n % 5 == 0) rd(1, "rand_opb");
        end

        // Reset during the HI pass.
        run_add(32'h1, 32'h2, 1'b0, 1'b1);
        wr(0, 32'hABCD_1234, 4'hF);
        wr(1, 32'h1111_2222, 4'hF);
        start(1'b1, 1'b1);
        check("lo_drive_a", {16'h0, add_a}, 32'h0000_1234);
        @(posedge clk);
        #1;
        check("hi_drive_a", {16'h0, add_a}, 32'h0000_ABCD);
        check("hi_drive_b", {16'h0, add_b}, 32'h0000_1111);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_add_a", {16'h0, add_a}, 32'h0);
        check("midrst_add_b", {16'h0, add_b}, 32'h0);
        rst = 1'b0;
        model_reset();
        for (int r = 0; r < 5; r++) rd(r, "midrst_reg");

        repeat (3) @(posedge clk);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
